// File: rtl/core_imem.sv
// core_imem: instruction memory with fixed-latency, in-order responses, outstanding limit and flush.
// Define CORE_IMEM_LOAD_EN to add the loader write port (load_we_i/load_addr_i/load_data_i).
module core_imem #(
    parameter int unsigned DEPTH_WORDS     = 1024,
    parameter int unsigned LATENCY         = 2,
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter logic [31:0] BASE_ADDR       = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        inst_req_i,
    output logic        inst_grnt_o,
    input  logic [31:0] inst_addr_i,
    output logic [31:0] inst_data_o,
    output logic        inst_valid_o,
    output logic        inst_err_o,
    input  logic        flush_i
`ifdef CORE_IMEM_LOAD_EN
    ,
    input  logic        load_we_i,
    input  logic [31:0] load_addr_i,
    input  logic [31:0] load_data_i
`endif
);
    localparam int unsigned   AW      = $clog2(DEPTH_WORDS);
    localparam int unsigned   CW      = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUTSTANDING);

    logic [31:0] mem [DEPTH_WORDS];

    logic [31:0]              rd_off;
    logic [AW-1:0]            rd_idx;
    logic                     rd_err;
    logic                     accept;
    logic                     retire;
    logic [CW-1:0]            count_q;
    logic [LATENCY-1:0]       pipe_v_q;
    logic [LATENCY-1:0]       pipe_err_q;
    logic [LATENCY-1:0][31:0] pipe_data_q;

    // Offset low bits equal the address low bits because BASE_ADDR is word-aligned;
    // any set bit above the index field means out of range, including wrap below BASE_ADDR.
    always_comb begin
        rd_off = inst_addr_i - BASE_ADDR;
        rd_idx = rd_off[AW+1:2];
        rd_err = (rd_off[1:0] != 2'b00) || (rd_off[31:AW+2] != '0);
    end

    always_comb begin
        inst_valid_o = pipe_v_q[LATENCY-1] && !flush_i && !rst_i;
        inst_err_o   = inst_valid_o && pipe_err_q[LATENCY-1];
        inst_data_o  = inst_valid_o ? pipe_data_q[LATENCY-1] : '0;
        retire       = inst_valid_o;
        inst_grnt_o  = !rst_i && ((count_q < MAX_CNT) || retire);
        accept       = inst_req_i && inst_grnt_o;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pipe_v_q <= '0;
            count_q  <= '0;
        end else begin
            pipe_v_q[0] <= accept;
            for (int unsigned i = 1; i < LATENCY; i++) begin
                pipe_v_q[i] <= flush_i ? 1'b0 : pipe_v_q[i-1];
            end
            if (flush_i) begin
                count_q <= accept ? CW'(1) : '0;
            end else if (accept && !retire) begin
                count_q <= count_q + CW'(1);
            end else if (!accept && retire) begin
                count_q <= count_q - CW'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (accept) begin
            pipe_err_q[0]  <= rd_err;
            pipe_data_q[0] <= rd_err ? '0 : mem[rd_idx];
        end
        for (int unsigned i = 1; i < LATENCY; i++) begin
            pipe_err_q[i]  <= pipe_err_q[i-1];
            pipe_data_q[i] <= pipe_data_q[i-1];
        end
    end

`ifdef CORE_IMEM_LOAD_EN
    logic [31:0] ld_off;
    logic        ld_err;

    always_comb begin
        ld_off = load_addr_i - BASE_ADDR;
        ld_err = (ld_off[1:0] != 2'b00) || (ld_off[31:AW+2] != '0);
    end

    // Non-blocking write: a same-edge read of the same word still sees the old data.
    always_ff @(posedge clk_i) begin
        if (load_we_i && !ld_err) begin
            mem[ld_off[AW+1:2]] <= load_data_i;
        end
    end
`endif

endmodule
